// File: rtl/uart_rx_core_if.sv
// rtl/uart_rx_core_if.sv - bus-side register interface of the UART receive path
//
// Groups the signals the UART register block uses to drain the RX FIFO and
// to read/clear the receive error flags.
//   fifoRe      pop the FIFO head (ignored while fifoEmpty)
//   clearErrors clear the sticky error flags at the next edge
//   dataOut     FIFO head byte, valid while fifoEmpty == 0
//   fifoEmpty   FIFO holds no bytes
//   fifoFull    FIFO holds 16 bytes
//   frameError  sticky: a stop bit was sampled as 0
//   overrun     sticky: a complete byte was dropped because the FIFO was full
// Modports: master = register block side, slave = receiver core side.

interface uart_rx_core_if;
  logic       fifoRe;
  logic       clearErrors;
  logic [7:0] dataOut;
  logic       fifoEmpty;
  logic       fifoFull;
  logic       frameError;
  logic       overrun;

  modport master (
    output fifoRe, clearErrors,
    input  dataOut, fifoEmpty, fifoFull, frameError, overrun
  );

  modport slave (
    input  fifoRe, clearErrors,
    output dataOut, fifoEmpty, fifoFull, frameError, overrun
  );
endinterface

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x oversampling 8N1 UART receiver with 16-entry RX FIFO
//
// Ports:
//   clock        system clock, rising edge
//   reset        synchronous active-low reset
//   baudDivisor  sample-tick period minus 1, in clock cycles
//   rxd          asynchronous serial input, idle high
//   rxActive     receiver is not idle (registered)
//   bus          FIFO drain / error flag interface (slave side)

module uart_rx_core (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] baudDivisor,
  input  logic        rxd,
  output logic        rxActive,
  uart_rx_core_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t      state;
  logic        rxd_meta;
  logic        rxd_s;
  logic [15:0] tick_div;
  logic [7:0]  tick_cnt;
  logic [7:0]  tick_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;

  logic [7:0]  mem [16];
  logic [3:0]  wr_ptr;
  logic [3:0]  rd_ptr;
  logic        empty;
  logic        full;
  logic        frame_error;
  logic        overrun_flag;

  logic        tick;
  logic        stop_sample;
  logic        stop_good;
  logic        frame_bad;
  logic        push;
  logic        pop;
  logic        drop;

  // Ticks only matter while a frame is being timed.
  assign tick        = (state != IDLE) && (state != BREAK) && (tick_div == 16'd0);
  assign tick_next   = tick_cnt + 8'd1;
  assign stop_sample = (state == STOP) && tick && (tick_next == 8'd152);
  assign stop_good   = stop_sample && rxd_s;
  assign frame_bad   = stop_sample && !rxd_s;
  assign pop         = bus.fifoRe && !empty;
  // A pop in the same cycle frees a slot even when full (full implies not empty).
  assign push        = stop_good && (!full || bus.fifoRe);
  assign drop        = stop_good && full && !bus.fifoRe;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      rxActive  <= 1'b0;
      tick_div  <= 16'd0;
      tick_cnt  <= 8'd0;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
    end else begin
      if (tick) begin
        tick_div <= baudDivisor;
        tick_cnt <= tick_next;
      end else if (tick_div != 16'd0) begin
        tick_div <= tick_div - 16'd1;
      end

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            // Reload here so tick k lands k*(baudDivisor+1) cycles after detection.
            state    <= START;
            rxActive <= 1'b1;
            tick_div <= baudDivisor;
            tick_cnt <= 8'd0;
            bit_cnt  <= 3'd0;
          end
        end
        START: begin
          if (tick && tick_next == 8'd8) begin
            if (rxd_s) begin
              state    <= IDLE;
              rxActive <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          // Mid-bit of each data bit falls on ticks 24, 40, ... 136.
          if (tick && tick_next[3:0] == 4'd8) begin
            shift_reg <= {rxd_s, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (stop_sample) begin
            if (rxd_s) begin
              state    <= IDLE;
              rxActive <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end
        end
        BREAK: begin
          // Wait for the line to recover so a held-low line cannot start a frame.
          if (rxd_s) begin
            state    <= IDLE;
            rxActive <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          rxActive <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      if (push && !pop) begin
        empty <= 1'b0;
        full  <= ((wr_ptr + 4'd1) == rd_ptr);
      end else if (pop && !push) begin
        full  <= 1'b0;
        empty <= ((rd_ptr + 4'd1) == wr_ptr);
      end
    end
  end

  // A new error outranks a coincident clear.
  always_ff @(posedge clock) begin
    if (!reset) begin
      frame_error  <= 1'b0;
      overrun_flag <= 1'b0;
    end else begin
      if (frame_bad)            frame_error <= 1'b1;
      else if (bus.clearErrors) frame_error <= 1'b0;
      if (drop)                 overrun_flag <= 1'b1;
      else if (bus.clearErrors) overrun_flag <= 1'b0;
    end
  end

  assign bus.dataOut    = mem[rd_ptr];
  assign bus.fifoEmpty  = empty;
  assign bus.fifoFull   = full;
  assign bus.frameError = frame_error;
  assign bus.overrun    = overrun_flag;

endmodule
